// File: rtl/ccr_pkg.sv
// ccr_pkg: CCR flag masks, condition-code values and FSM
// state encoding shared by the ALU side and branch evaluation.
package ccr_pkg;

  localparam logic [3:0] CCR_C = 4'b1000;
  localparam logic [3:0] CCR_V = 4'b0100;
  localparam logic [3:0] CCR_N = 4'b0010;
  localparam logic [3:0] CCR_Z = 4'b0001;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ccr_branch_eval_if.sv
// ccr_branch_eval_if: request and response handshakes
// between the sequencer (master) and branch evaluator (slave).
interface ccr_branch_eval_if #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       cond;
  logic [PC_W-1:0]  pc;
  logic [OFF_W-1:0] offset;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             taken;
  logic [PC_W-1:0]  target;

  modport master (
    output req_valid, cond, pc, offset,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  taken, target
  );

  modport slave (
    input  req_valid, cond, pc, offset,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output taken, target
  );
endinterface

// File: rtl/ccr_cond_decode.sv
// ccr_cond_decode: evaluates one of 16 condition codes
// against a CVNZ flag vector.
module ccr_cond_decode
  import ccr_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_ccr,
  output logic       o_taken
);

  logic w_c, w_v, w_n, w_z;

  assign w_c = |(i_ccr & CCR_C);
  assign w_v = |(i_ccr & CCR_V);
  assign w_n = |(i_ccr & CCR_N);
  assign w_z = |(i_ccr & CCR_Z);

  always_comb begin
    o_taken = 1'b0;
    unique case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = !w_z;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = !w_c;
      COND_MI: o_taken = w_n;
      COND_PL: o_taken = !w_n;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = !w_v;
      COND_HI: o_taken = w_c && !w_z;
      COND_LS: o_taken = !w_c || w_z;
      COND_GE: o_taken = (w_n == w_v);
      COND_LT: o_taken = (w_n != w_v);
      COND_GT: o_taken = !w_z && (w_n == w_v);
      COND_LE: o_taken = w_z || (w_n != w_v);
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ccr_branch_eval.sv
// ccr_branch_eval: holds the CCR and resolves branch
// requests into taken/next-PC over valid/ready handshakes.
module ccr_branch_eval
  import ccr_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int OFF_W  = 4,
  parameter int PC_INC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ccr_we,
  input  logic [3:0] ccr_in,
  output logic [3:0] ccr_q,
  ccr_branch_eval_if.slave bus
);

  state_t r_state;
  state_t w_next;

  logic [3:0]       r_ccr;
  logic [3:0]       r_snap;
  logic [3:0]       r_cond;
  logic [PC_W-1:0]  r_pc;
  logic [OFF_W-1:0] r_off;
  logic             r_taken;
  logic [PC_W-1:0]  r_target;

  logic             w_accept;
  logic             w_taken;
  logic [PC_W-1:0]  w_sext;

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);
  assign w_sext   = PC_W'($signed(r_off));

  assign ccr_q         = r_ccr;
  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.taken     = r_taken;
  assign bus.target    = r_target;

  ccr_cond_decode u_dec (
    .i_cond  (r_cond),
    .i_ccr   (r_snap),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.req_valid) w_next = ST_EVAL;
      ST_EVAL: w_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ccr <= 4'b0000;
    else if (ccr_we) r_ccr <= ccr_in;
  end

  // Snapshot forwards a same-edge ALU write so the branch
  // sees the flags of the instruction just before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= 4'b0000;
      r_cond <= 4'b0000;
      r_pc   <= '0;
      r_off  <= '0;
    end else if (w_accept) begin
      r_snap <= ccr_we ? ccr_in : r_ccr;
      r_cond <= bus.cond;
      r_pc   <= bus.pc;
      r_off  <= bus.offset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken  <= 1'b0;
      r_target <= '0;
    end else if (r_state == ST_EVAL) begin
      r_taken  <= w_taken;
      r_target <= w_taken ? (r_pc + w_sext)
                          : (r_pc + PC_W'(PC_INC));
    end
  end

endmodule
